// File: rtl/btb_update_ctrl.sv
// BTB update sequencer: clear sweep, pending-update FIFO, 2-bit counter RMW, read-port arbitration.
// Optional BTB_UPD_STATS_EN adds wrapping activity counters.
module btb_update_ctrl #(
  parameter int IDX_W      = 6,
  parameter int TAG_W      = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_req,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [IDX_W-1:0]      upd_index,
  input  logic [TAG_W-1:0]      upd_tag,
  input  logic [31:0]           upd_target,
  input  logic                  upd_taken,
  input  logic                  upd_jump,
  input  logic                  fetch_rd_req,
  output logic                  fetch_stall,
  output logic                  btb_rd_en,
  output logic [IDX_W-1:0]      btb_rd_index,
  input  logic [3+32+TAG_W-1:0] btb_rd_data,
  output logic                  btb_wr_en,
  output logic [IDX_W-1:0]      btb_wr_index,
  output logic [3+32+TAG_W-1:0] btb_wr_data,
  output logic                  init_busy
`ifdef BTB_UPD_STATS_EN
  ,
  output logic [15:0]           stat_upd_cnt,
  output logic [15:0]           stat_alloc_cnt,
  output logic [15:0]           stat_steal_cnt
`endif
);

  localparam int ENT_W = 3 + 32 + TAG_W;
  localparam int Q_W   = IDX_W + TAG_W + 34;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [PTR_W:0]   FULL_CNT   = FIFO_DEPTH[PTR_W:0];
  localparam logic [CNT_W-1:0] STARVE_LIM = STARVE_MAX[CNT_W-1:0];

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD, S_WR} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   sweep_reg;
  logic [Q_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic [Q_W-1:0]     work_reg;
  logic [ENT_W-1:0]   rd_data_reg;
  logic [CNT_W-1:0]   starve_reg;

  logic               fifo_full, fifo_empty, push, pop, kill;
  logic [Q_W-1:0]     head;
  logic [IDX_W-1:0]   w_index;
  logic [TAG_W-1:0]   w_tag;
  logic [31:0]        w_target;
  logic               w_taken, w_jump;
  logic [1:0]         s_state, new_state;
  logic               s_valid, hit;
  logic [TAG_W-1:0]   s_tag;
  logic               unused_rd_target;

  assign kill       = rst | flush_req;
  assign fifo_full  = (count_reg == FULL_CNT);
  assign fifo_empty = (count_reg == '0);
  assign upd_ready  = !fifo_full && (state_reg != S_INIT) && !kill;
  assign push       = upd_valid && upd_ready;
  assign pop        = (state_reg == S_RD) && !kill;
  assign head       = fifo_mem[rd_ptr_reg];

  assign {w_index, w_tag, w_target, w_taken, w_jump} = work_reg;
  assign s_state = rd_data_reg[ENT_W-1 -: 2];
  assign s_valid = rd_data_reg[ENT_W-3];
  assign s_tag   = rd_data_reg[TAG_W-1:0];
  assign hit     = s_valid && (s_tag == w_tag);
  assign unused_rd_target = ^rd_data_reg[TAG_W +: 32];

  always_comb begin
    new_state = 2'b00;
    if (w_jump)
      new_state = 2'b11;
    else if (hit)
      new_state = w_taken ? ((s_state == 2'b11) ? 2'b11 : s_state + 2'd1)
                          : ((s_state == 2'b00) ? 2'b00 : s_state - 2'd1);
    else
      new_state = w_taken ? 2'b10 : 2'b01;
  end

  // State register
  always_ff @(posedge clk) begin
    if (kill) state_reg <= S_INIT;
    else      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_INIT: if (sweep_reg == '1) state_next = S_IDLE;
      S_IDLE: if (!fifo_empty && (!fetch_rd_req || starve_reg == STARVE_LIM)) state_next = S_RD;
      S_RD:   state_next = S_WR;
      S_WR:   state_next = (!fifo_empty && !fetch_rd_req) ? S_RD : S_IDLE;
      default: state_next = S_INIT;
    endcase
  end

  // Outputs; reset forces the quiet values, flush only kills the write
  always_comb begin
    btb_rd_en    = 1'b0;
    btb_rd_index = head[Q_W-1 -: IDX_W];
    btb_wr_en    = 1'b0;
    btb_wr_index = sweep_reg;
    btb_wr_data  = '0;
    fetch_stall  = 1'b0;
    init_busy    = rst || (state_reg == S_INIT);
    case (state_reg)
      S_INIT: begin
        btb_wr_en   = 1'b1;
        fetch_stall = fetch_rd_req;
      end
      S_RD: begin
        btb_rd_en   = 1'b1;
        fetch_stall = fetch_rd_req;
      end
      S_WR: begin
        btb_wr_en    = 1'b1;
        btb_wr_index = w_index;
        btb_wr_data  = {new_state, 1'b1, w_target, w_tag};
      end
      default: ;
    endcase
    if (kill) btb_wr_en = 1'b0;
    if (rst) begin
      btb_rd_en   = 1'b0;
      fetch_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {upd_index, upd_tag, upd_target, upd_taken, upd_jump};
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      sweep_reg   <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      work_reg    <= '0;
      rd_data_reg <= '0;
      starve_reg  <= '0;
    end else begin
      if (state_reg == S_INIT) sweep_reg <= sweep_reg + 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      if (state_next == S_RD && state_reg != S_RD)
        starve_reg <= '0;
      else if (state_reg == S_IDLE && !fifo_empty && fetch_rd_req && starve_reg != STARVE_LIM)
        starve_reg <= starve_reg + 1'b1;
      if (pop) begin
        work_reg    <= head;
        rd_data_reg <= btb_rd_data;
      end
    end
  end

`ifdef BTB_UPD_STATS_EN
  always_ff @(posedge clk) begin
    if (kill) begin
      stat_upd_cnt   <= '0;
      stat_alloc_cnt <= '0;
      stat_steal_cnt <= '0;
    end else begin
      if (state_reg == S_WR) stat_upd_cnt <= stat_upd_cnt + 16'd1;
      if (state_reg == S_WR && !hit) stat_alloc_cnt <= stat_alloc_cnt + 16'd1;
      if (state_reg == S_RD && fetch_rd_req) stat_steal_cnt <= stat_steal_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: shadow BTB model predicts every write, monitor compares.
module tb_btb_update_ctrl;
  localparam int IDX_W = 6;
  localparam int TAG_W = 24;
  localparam int ENT_W = 3 + 32 + TAG_W;
  localparam int NENT  = 64;
  localparam int SMAX  = 8;

  logic clk = 0, rst = 1, flush_req = 0;
  logic upd_valid = 0, upd_ready, upd_taken = 0, upd_jump = 0;
  logic [IDX_W-1:0] upd_index = 0;
  logic [TAG_W-1:0] upd_tag = 0;
  logic [31:0] upd_target = 0;
  logic fetch_rd_req = 0, fetch_stall, btb_rd_en, btb_wr_en, init_busy;
  logic [IDX_W-1:0] btb_rd_index, btb_wr_index;
  logic [ENT_W-1:0] btb_rd_data, btb_wr_data;

  btb_update_ctrl dut (
    .clk(clk), .rst(rst), .flush_req(flush_req),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index), .upd_tag(upd_tag),
    .upd_target(upd_target), .upd_taken(upd_taken), .upd_jump(upd_jump),
    .fetch_rd_req(fetch_rd_req), .fetch_stall(fetch_stall),
    .btb_rd_en(btb_rd_en), .btb_rd_index(btb_rd_index), .btb_rd_data(btb_rd_data),
    .btb_wr_en(btb_wr_en), .btb_wr_index(btb_wr_index), .btb_wr_data(btb_wr_data),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  // Environment BTB storage with combinational read
  logic [ENT_W-1:0] btb_mem [NENT];
  assign btb_rd_data = btb_mem[btb_rd_index];
  always @(posedge clk) if (btb_wr_en) btb_mem[btb_wr_index] <= btb_wr_data;

  typedef struct { logic [IDX_W-1:0] idx; logic [ENT_W-1:0] data; } exp_t;
  exp_t exp_q[$];

  int sh_state [NENT];
  bit sh_valid [NENT];
  logic [TAG_W-1:0] sh_tag [NENT];
  int total = 0, bad = 0, init_exp = 0, n_upd = 0;
  bit rand_fetch = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < NENT; i++) begin
      sh_state[i] = 0; sh_valid[i] = 0; sh_tag[i] = '0;
    end
    init_exp = 0;
  endtask

  // Reference: in-order updates applied to a shadow table
  task automatic model_push(int idx, logic [TAG_W-1:0] tag, logic [31:0] tgt, bit taken, bit jump);
    int st;
    logic [1:0] s2;
    exp_t e;
    if (jump) st = 3;
    else if (sh_valid[idx] && sh_tag[idx] == tag) begin
      st = sh_state[idx] + (taken ? 1 : -1);
      if (st > 3) st = 3;
      if (st < 0) st = 0;
    end else st = taken ? 2 : 1;
    sh_state[idx] = st; sh_valid[idx] = 1; sh_tag[idx] = tag;
    s2 = st[1:0];
    e.idx = idx[IDX_W-1:0];
    e.data = {s2, 1'b1, tgt, tag};
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (rand_fetch) fetch_rd_req = 1'($urandom_range(0, 1));
  endtask

  // Drives one update and holds it until accepted; leaves upd_valid high
  task automatic send(int idx, logic [TAG_W-1:0] tag, logic [31:0] tgt, bit taken, bit jump);
    bit done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      tick();
      upd_valid = 1; upd_index = idx[IDX_W-1:0]; upd_tag = tag;
      upd_target = tgt; upd_taken = taken; upd_jump = jump;
      @(negedge clk);
      if (upd_ready) begin
        model_push(idx, tag, tgt, taken, jump);
        done = 1;
      end
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin tick(); n++; end
    chk("drain_timeout", 64'(exp_q.size()), 0);
    repeat (3) tick();
  endtask

  task automatic wait_init(string name);
    int n = 0;
    @(negedge clk);
    while (init_busy && n < 300) begin @(negedge clk); n++; end
    chk({name, "_sweep_len"}, 64'(init_exp), NENT);
    chk({name, "_ready_rise"}, 64'(upd_ready), 1);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (btb_wr_en && init_busy) begin
        chk("init_idx", 64'(btb_wr_index), 64'(init_exp));
        chk("init_data", 64'(btb_wr_data), 0);
        init_exp++;
      end else if (btb_wr_en) begin
        chk("wr_fetch_stall", 64'(fetch_stall), 0);
        if (exp_q.size() == 0) chk("unexpected_wr", 64'(btb_wr_index), 64'hFFFF);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          n_upd++;
          $display("upd %0d: idx=%0d data=%h exp_idx=%0d exp_data=%h", n_upd, btb_wr_index,
                   btb_wr_data, e.idx, e.data);
          chk("wr_idx", 64'(btb_wr_index), 64'(e.idx));
          chk("wr_data", 64'(btb_wr_data), 64'(e.data));
        end
      end
      if (btb_rd_en) begin
        chk("rd_fetch_stall", 64'(fetch_stall), 64'(fetch_rd_req));
        chk("rd_in_init", 64'(init_busy), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    model_clear();
    upd_valid = 1;
    fetch_rd_req = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_upd_ready", 64'(upd_ready), 0);
    chk("rst_wr_en", 64'(btb_wr_en), 0);
    chk("rst_rd_en", 64'(btb_rd_en), 0);
    chk("rst_fetch_stall", 64'(fetch_stall), 0);
    chk("rst_init_busy", 64'(init_busy), 1);
    @(posedge clk); #1;
    rst = 0; upd_valid = 0; fetch_rd_req = 0;
    init_exp = 0;
    wait_init("boot");

    // Miss taken then four not-taken to the same index
    send(5, 24'h12, 32'h400, 1, 0);
    for (int i = 0; i < 4; i++) send(5, 24'h12, 32'h400, 0, 0);
    tick(); upd_valid = 0;
    drain();
    chk("idx5_final", 64'(btb_mem[5]), 64'({2'b00, 1'b1, 32'h400, 24'h12}));

    // Jump replacing a different tag
    send(9, 24'hA, 32'h900, 1, 0);
    send(9, 24'hB, 32'h1234, 0, 1);
    tick(); upd_valid = 0;
    drain();
    chk("idx9_jump", 64'(btb_mem[9]), 64'({2'b11, 1'b1, 32'h1234, 24'hB}));

    // Starvation: fetch holds the port, the update must wait then steal
    fetch_rd_req = 1;
    send(12, 24'h3, 32'h40, 1, 0);
    tick(); upd_valid = 0;
    cnt = 0;
    @(negedge clk); cnt = 1;
    while (!btb_rd_en && cnt < 50) begin @(negedge clk); cnt++; end
    chk("steal_latency", 64'(cnt), 64'(SMAX + 2));
    drain();

    // Fill FIFO while fetch busy
    for (int i = 0; i < 4; i++) send(20 + i, 24'h50 + i, 32'h1000 + i, i % 2, 0);
    tick(); upd_index = 30;
    @(negedge clk);
    chk("full_ready", 64'(upd_ready), 0);
    tick(); upd_valid = 0; fetch_rd_req = 0;
    drain();

    // Flush during WR with two updates still queued
    send(33, 24'h7, 32'h77, 1, 0);
    send(34, 24'h8, 32'h88, 1, 0);
    send(35, 24'h9, 32'h99, 1, 0);
    chk("rd_before_flush", 64'(btb_rd_en), 1);
    tick();
    flush_req = 1; upd_index = 40;
    model_clear();
    @(negedge clk);
    chk("flush_wr_suppressed", 64'(btb_wr_en), 0);
    chk("flush_upd_dropped", 64'(upd_ready), 0);
    tick(); flush_req = 0; upd_valid = 0;
    wait_init("flush");
    repeat (20) tick();
    chk("flush_queue_empty", 64'(exp_q.size()), 0);

    // Randomised traffic with a rare flush
    rand_fetch = 1;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        tick();
        upd_valid = 0; flush_req = 1;
        model_clear();
        tick(); flush_req = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        tick(); upd_valid = 0;
      end else begin
        send($urandom_range(0, 7), 24'($urandom_range(1, 3)), $urandom,
             1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
      end
    end
    tick(); upd_valid = 0;
    rand_fetch = 0; fetch_rd_req = 0;
    drain();
    chk("final_queue_empty", 64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
- Sequences all accesses to the branch target buffer (BTB) other than fetch lookups.
- Runs a post-reset/flush clear sweep and buffers decode-stage resolve updates in a small FIFO.
- Performs read-modify-write of the 2-bit saturating state for each buffered update.
- Arbitrates the single BTB read port against fetch, with starvation protection.

Parameters:
- IDX_W, 6, BTB index width; BTB has 2**IDX_W entries
- TAG_W, 24, tag width
- FIFO_DEPTH, 4, pending-update FIFO entries (power of 2, >=2)
- STARVE_MAX, 8, max consecutive denied cycles before an update steals the read port

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush_req  in  1  one-cycle pulse: discard pending updates and re-clear BTB
- upd_valid  in  1  decode presents a resolved branch/jump
- upd_ready  out  1  update accepted when upd_valid&upd_ready
- upd_index  in  IDX_W  BTB index of resolved instruction
- upd_tag  in  TAG_W  tag of resolved instruction
- upd_target  in  32  resolved target
- upd_taken  in  1  branch outcome (ignored for jumps)
- upd_jump  in  1  1 = unconditional jump
- fetch_rd_req  in  1  fetch wants the BTB read port this cycle
- fetch_stall  out  1  fetch denied the read port this cycle
- btb_rd_en  out  1  controller drives the read port
- btb_rd_index  out  IDX_W  read index when btb_rd_en
- btb_rd_data  in  3+32+TAG_W  combinational read data {state[1:0],valid,target,tag}
- btb_wr_en  out  1  write strobe
- btb_wr_index  out  IDX_W  write index
- btb_wr_data  out  3+32+TAG_W  write data, same format
- init_busy  out  1  clear sweep in progress; fetch must not predict

Behaviour:
- States: INIT, IDLE, RD, WR.
- Reset:
  - Enters INIT with sweep counter 0 and FIFO empty.
  - Outputs during reset: upd_ready=0, btb_wr_en=0, btb_rd_en=0, fetch_stall=0, init_busy=1.
- INIT:
  - Writes all-zero entry to index = counter; counter increments each cycle.
  - Lasts exactly 2**IDX_W cycles, then goes to IDLE.
  - init_busy=1 throughout. fetch_stall=fetch_rd_req. upd_ready=0.
- FIFO:
  - Accepts an update when upd_valid&upd_ready.
  - upd_ready = !full && state!=INIT && !flush_req.
  - Push and pop in the same cycle are both allowed. When full, a pop in the same cycle does not raise upd_ready (registered full).
- IDLE:
  - If FIFO is non-empty and (fetch_rd_req==0 or starve count==STARVE_MAX), go to RD.
  - Otherwise, if non-empty and fetch_rd_req==1, starve count increments, saturating at STARVE_MAX.
  - Starve count clears on entering RD.
- RD (1 cycle):
  - btb_rd_en=1, btb_rd_index=head.index.
  - fetch_stall=fetch_rd_req.
  - Register btb_rd_data, pop head into a working register, go to WR.
- WR (1 cycle):
  - hit = stored.valid && stored.tag==work.tag.
  - New state:
    - jump: 2'b11.
    - hit branch: saturating +1 if taken, saturating -1 if not taken.
    - miss branch: 2'b10 if taken, 2'b01 if not.
  - Writes {newstate,1'b1,work.target,work.tag} to work.index.
  - Next state is RD if FIFO is non-empty and fetch_rd_req==0, else IDLE.
  - Read port is free in WR; fetch_stall=0.
- Update throughput: 2 cycles per update. Back-to-back updates to the same index are correct because each WR precedes the next RD.
- flush_req:
  - In any state, has priority over everything.
  - Next cycle is INIT with counter 0, FIFO and working register cleared, starve count 0.
  - An in-flight WR on the flush cycle is suppressed (btb_wr_en=0).
  - An upd_valid on the flush cycle is dropped (upd_ready=0).
  - A flush during INIT restarts the sweep at 0.
- rst mid-operation behaves exactly as flush, plus reset output values.
- btb_wr_en is high only in INIT and WR.

Optional Feature:
- Macro: BTB_UPD_STATS_EN.
- When defined, adds outputs:
  - stat_upd_cnt[15:0]: completed WRs.
  - stat_alloc_cnt[15:0]: WRs with miss.
  - stat_steal_cnt[15:0]: RDs entered with fetch_rd_req=1.
- All counters are wrapping, cleared by rst and flush_req.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset released -> btb_wr_en=1 for 64 consecutive cycles, indices 0..63, data 0. init_busy falls on cycle 64. upd_ready rises the same cycle.
- Miss branch, taken, idx 5, tag 0x12, target 0x400, fetch idle -> RD cycle, then WR to idx 5 with data {10,1,0x400,0x12}. Four more not-taken updates to idx 5 -> states 01, 00, 00, 00.
- Jump idx 9 when the entry holds a different tag -> write state 11, valid 1, new tag.
- fetch_rd_req held high, one update queued -> no RD for 8 cycles. Cycle 9 is RD with fetch_stall=1. WR follows with fetch_stall=0.
- Push 4 updates while fetch busy -> upd_ready=0 on the 5th. All four drain in order with indices matching.
- flush_req asserted during WR with 2 queued -> that write suppressed, FIFO empty, full 64-cycle sweep follows, queued updates never written.
